// File: rtl/maxpool_relu_stream_if.sv
// Stream/control bundle for maxpool_relu_stream: start/status, input samples, pooled outputs.
interface maxpool_relu_stream_if #(
    parameter int unsigned DATA_W = 69
) ();
    logic                     pool_start;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic        [DATA_W-1:0] out_data;
    logic                     busy;
    logic                     pool_done;

    modport slave (
        input  pool_start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, pool_done
    );

    modport master (
        output pool_start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, pool_done
    );
endinterface

// File: rtl/maxpool_relu_stream.sv
// 2x2 stride-2 max pooling followed by ReLU over a raster-ordered signed sample stream.
// Top pooling row is folded into a half-width line buffer; bottom row completes each window.
module maxpool_relu_stream #(
    parameter int unsigned DATA_W = 69,
    parameter int unsigned IN_X   = 24,
    parameter int unsigned IN_Y   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    maxpool_relu_stream_if.slave   bus
);
    localparam int unsigned ROW_W = (IN_X > 1) ? $clog2(IN_X) : 1;
    localparam int unsigned COL_W = (IN_Y > 1) ? $clog2(IN_Y) : 1;
    localparam int unsigned LB_N  = IN_Y / 2;
    localparam int unsigned LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     pool_done_q, pool_done_d;
    logic signed [DATA_W-1:0] line_buf_q [LB_N];

    logic                     in_ready_c;
    logic                     in_fire;
    logic                     out_fire;
    logic                     last_col;
    logic                     last_row;
    logic                     lb_we;
    logic [LB_AW-1:0]         lb_idx;
    logic signed [DATA_W-1:0] lb_wdata;
    logic signed [DATA_W-1:0] win_max;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Input stalls only while a pooled result is waiting and cannot leave this cycle.
    assign in_ready_c = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    assign in_fire    = bus.in_valid && in_ready_c;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign last_col   = (col_q == COL_W'(IN_Y - 1));
    assign last_row   = (row_q == ROW_W'(IN_X - 1));
    assign lb_idx     = LB_AW'(col_q >> 1);
    assign win_max    = smax(smax(line_buf_q[lb_idx], hold_q), bus.in_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pool_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            pool_done_q <= pool_done_d;
        end
    end

    // Contents need no reset: every entry is rewritten on each even row before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf_q[lb_idx] <= lb_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        pool_done_d = 1'b0;
        lb_we       = 1'b0;
        lb_wdata    = smax(hold_q, bus.in_data);

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.pool_start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                if (in_fire) begin
                    if (!col_q[0]) begin
                        hold_d = bus.in_data;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_data_d  = win_max[DATA_W-1] ? '0 : win_max;
                        out_valid_d = 1'b1;
                    end

                    if (last_col) begin
                        col_d = '0;
                        row_d = last_row ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end

                    if (last_col && last_row) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d     = IDLE;
                    pool_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.pool_done = pool_done_q;
endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Randomized self-checking bench for maxpool_relu_stream against a window-max/ReLU reference model.
module tb_maxpool_relu_stream;
    localparam int unsigned DATA_W = 69;
    localparam int unsigned IN_X   = 24;
    localparam int unsigned IN_Y   = 24;
    localparam int          NBEAT  = IN_X * IN_Y;
    localparam int          NOUT   = NBEAT / 4;

    typedef logic signed [DATA_W-1:0] sample_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    maxpool_relu_stream_if #(.DATA_W(DATA_W)) bus ();

    maxpool_relu_stream #(
        .DATA_W(DATA_W),
        .IN_X  (IN_X),
        .IN_Y  (IN_Y)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int      n_tests;
    int      n_fail;
    int      done_cnt;
    int      out_cnt;
    int      out_gap;
    bit      stall_mode;
    sample_t in_map [IN_X][IN_Y];
    sample_t exp_q [$];

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each output is the ReLU of the largest of its four window samples.
    function automatic void build_expected();
        sample_t m;
        exp_q.delete();
        for (int r = 0; r < int'(IN_X / 2); r++) begin
            for (int c = 0; c < int'(IN_Y / 2); c++) begin
                m = in_map[2*r][2*c];
                if (in_map[2*r][2*c+1]   > m) m = in_map[2*r][2*c+1];
                if (in_map[2*r+1][2*c]   > m) m = in_map[2*r+1][2*c];
                if (in_map[2*r+1][2*c+1] > m) m = in_map[2*r+1][2*c+1];
                if (m < 0) m = '0;
                exp_q.push_back(m);
            end
        end
    endfunction

    function automatic sample_t rand_sample();
        logic [95:0] t;
        if ($urandom_range(3) == 0) begin
            return sample_t'(int'($urandom_range(20)) - 10);
        end
        t = {$urandom, $urandom, $urandom};
        return sample_t'(t[DATA_W-1:0]);
    endfunction

    function automatic void fill_ramp();
        for (int r = 0; r < int'(IN_X); r++)
            for (int c = 0; c < int'(IN_Y); c++)
                in_map[r][c] = sample_t'(r * int'(IN_Y) + c);
    endfunction

    function automatic void fill_const(input sample_t v);
        for (int r = 0; r < int'(IN_X); r++)
            for (int c = 0; c < int'(IN_Y); c++)
                in_map[r][c] = v;
    endfunction

    function automatic void fill_random();
        for (int r = 0; r < int'(IN_X); r++)
            for (int c = 0; c < int'(IN_Y); c++)
                in_map[r][c] = rand_sample();
    endfunction

    task automatic monitor_loop();
        bit      stall_prev = 1'b0;
        sample_t prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", DATA_W'(bus.out_valid), DATA_W'(1));
                    check("hold_data", bus.out_data, prev_data);
                end
                if (bus.out_valid && !bus.out_ready)
                    check("inrdy_backpressure", DATA_W'(bus.in_ready), '0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() > 0)
                        check("out_data", bus.out_data, exp_q.pop_front());
                    out_cnt++;
                end
                if (bus.pool_done) begin
                    done_cnt++;
                    check("done_in_idle", DATA_W'(bus.busy), '0);
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    endtask

    task automatic ready_loop();
        int stall_left = 0;
        bit stalled    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                stalled = 1'b0;
            end else if (!stalled && bus.out_valid) begin
                stalled    = 1'b1;
                stall_left = 60;
            end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = (int'($urandom_range(99)) >= out_gap);
            end
        end
    endtask

    task automatic drive_map(input int in_gap, input int extra_start_beat, input int rst_beat);
        int beat   = 0;
        int cycles = 0;
        int base_out;
        int base_done;
        bit fire;
        build_expected();
        base_out  = out_cnt;
        base_done = done_cnt;
        @(posedge clk); #1;
        bus.pool_start = 1'b1;
        @(posedge clk); #1;
        bus.pool_start = 1'b0;
        check("busy_run", DATA_W'(bus.busy), DATA_W'(1));
        while (beat < NBEAT && cycles < 20000) begin
            if (beat == rst_beat) begin
                rst          = 1'b0;
                bus.in_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_out_valid", DATA_W'(bus.out_valid), '0);
                    check("rst_in_ready", DATA_W'(bus.in_ready), '0);
                    check("rst_busy", DATA_W'(bus.busy), '0);
                end
                exp_q.delete();
                @(posedge clk); #1;
                rst = 1'b1;
                check("rst_no_done", DATA_W'(done_cnt - base_done), '0);
                return;
            end
            bus.in_valid   = (int'($urandom_range(99)) >= in_gap);
            bus.in_data    = in_map[beat / int'(IN_Y)][beat % int'(IN_Y)];
            bus.pool_start = (beat == extra_start_beat);
            @(negedge clk);
            fire = bus.in_valid && bus.in_ready;
            if (fire && beat == int'(IN_Y) + 1)
                check("latency_pre", DATA_W'(bus.out_valid), '0);
            @(posedge clk); #1;
            if (fire) begin
                if (beat == int'(IN_Y) + 1)
                    check("latency_post", DATA_W'(bus.out_valid), DATA_W'(1));
                beat++;
            end
            cycles++;
        end
        bus.in_valid   = 1'b0;
        bus.pool_start = 1'b0;
        check("in_beats", DATA_W'(beat), DATA_W'(NBEAT));
        cycles = 0;
        while (bus.busy && cycles < 5000) begin
            @(negedge clk);
            cycles++;
        end
        @(posedge clk); #1;
        check("drained", DATA_W'(bus.busy), '0);
        check("out_count", DATA_W'(out_cnt - base_out), DATA_W'(NOUT));
        check("done_count", DATA_W'(done_cnt - base_done), DATA_W'(1));
    endtask

    initial begin
        sample_t big;
        int      base_done;
        n_tests        = 0;
        n_fail         = 0;
        done_cnt       = 0;
        out_cnt        = 0;
        out_gap        = 0;
        stall_mode     = 1'b0;
        rst            = 1'b0;
        bus.pool_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;

        fork
            monitor_loop();
            ready_loop();
        join_none

        repeat (2) @(negedge clk);
        check("reset_out_valid", DATA_W'(bus.out_valid), '0);
        check("reset_out_data", bus.out_data, '0);
        check("reset_in_ready", DATA_W'(bus.in_ready), '0);
        check("reset_busy", DATA_W'(bus.busy), '0);
        check("reset_pool_done", DATA_W'(bus.pool_done), '0);
        @(posedge clk); #1;
        rst = 1'b1;

        fill_ramp();
        drive_map(0, -1, -1);

        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", DATA_W'(bus.in_ready), '0);
            check("idle_out_valid", DATA_W'(bus.out_valid), '0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        fill_const(sample_t'(-5));
        drive_map(0, -1, -1);

        fill_const(sample_t'(-5));
        in_map[0][0] = sample_t'(-7);
        in_map[0][1] = sample_t'(3);
        in_map[1][0] = sample_t'(-1);
        in_map[1][1] = sample_t'(-2);
        big = '1;
        big[DATA_W-1] = 1'b0;
        in_map[1][3] = big;
        in_map[2][4] = big;
        drive_map(0, -1, -1);

        fill_ramp();
        stall_mode = 1'b1;
        drive_map(0, -1, -1);
        stall_mode = 1'b0;

        out_gap   = 50;
        base_done = done_cnt;
        repeat (3) begin
            fill_random();
            drive_map(50, -1, -1);
        end
        check("done_three_maps", DATA_W'(done_cnt - base_done), DATA_W'(3));
        out_gap = 0;

        fill_ramp();
        drive_map(0, 100, -1);

        fill_ramp();
        drive_map(0, -1, 300);
        drive_map(0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/maxpool_relu_stream.md
MAXPOOL_RELU_STREAM -- requirements
Module: maxpool_relu_stream

Interface
REQ-001 Parameter DATA_W, default 69, signed sample width; matches the convolution result width.
REQ-002 Parameter IN_X, default 24, input feature-map rows.
REQ-003 Parameter IN_Y, default 24, input feature-map columns; IN_X and IN_Y SHALL be even.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is supplied externally.
REQ-006 pool_start  input  1  one-cycle request to begin pooling one feature map.
REQ-007 in_valid  input  1  in_data holds a valid convolution sample.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 in_data  input  DATA_W  signed convolution sample, raster order (row-major, column fastest).
REQ-010 out_valid  output  1  out_data holds a valid pooled sample.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  pooled, ReLU-clipped sample, always >= 0.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 pool_done  output  1  one-cycle pulse when the final pooled sample is accepted.

Function
REQ-015 The block SHALL perform 2x2 stride-2 max pooling followed by ReLU: out[r][c] = max(0, max of in[2r..2r+1][2c..2c+1]), producing (IN_X/2)*(IN_Y/2) outputs in raster order.
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN; IDLE->RUN on pool_start; RUN->DRAIN on acceptance of input beat IN_X*IN_Y; DRAIN->IDLE when the last output is accepted.
REQ-017 pool_start in RUN or DRAIN SHALL be ignored.
REQ-018 A beat SHALL be transferred when in_valid && in_ready; out transfer when out_valid && out_ready.
REQ-019 in_ready SHALL be high only in RUN and when (!out_valid || out_ready).
REQ-020 Row counter (0..IN_X-1) and column counter (0..IN_Y-1) SHALL advance only on input transfers; column wraps to 0 and increments row; both clear on entering RUN.
REQ-021 Even row, even column: hold register := in_data; even row, odd column: line buffer[col/2] := max(hold, in_data).
REQ-022 Odd row, even column: hold register := in_data; odd row, odd column: out_data := ReLU(max(line buffer[col/2], hold, in_data)), out_valid := 1 on the next edge.
REQ-023 Latency SHALL be one cycle from the transfer of the (odd row, odd column) beat to out_valid.
REQ-024 All comparisons SHALL be signed DATA_W-bit; no truncation or widening; ReLU maps any negative value (MSB set) to 0.
REQ-025 out_valid SHALL remain high with out_data stable until transferred; a new output and the transfer of the old one may occur in the same cycle.
REQ-026 Line buffer SHALL hold IN_Y/2 entries of DATA_W bits; it is fully rewritten each even row so no clearing between maps is required.
REQ-027 in_valid in IDLE or DRAIN SHALL be ignored (in_ready low).
REQ-028 pool_done SHALL pulse in the cycle after the last output transfer, coinciding with return to IDLE.

Reset
REQ-029 On rst low: state=IDLE, counters=0, out_valid=0, out_data=0, busy=0, pool_done=0, in_ready=0, hold=0; line buffer contents are don't-care.
REQ-030 Reset asserted mid-map SHALL abandon the map immediately; no pool_done is produced and the next pool_start begins a fresh map.

Verification
REQ-031 Ramp map in[r][c]=r*24+c, out_ready=1, in_valid=1 -> 144 outputs, out[r][c]=(2r+1)*24+2c+1, pool_done once after output 144.
REQ-032 All inputs -5 -> all 144 outputs 0; window {-7,3,-1,-2} -> 3; window with max = 2^68-1 passes unchanged.
REQ-033 out_ready held low after first output -> in_ready drops, no data lost; release -> remaining outputs identical to REQ-031.
REQ-034 Random in_valid and out_ready gaps (50%) over 3 back-to-back maps -> outputs match a software model; pool_done 3 times.
REQ-035 pool_start pulsed in RUN at beat 100 -> ignored, counters unaffected, result identical to REQ-031.
REQ-036 rst low at beat 300, then pool_start and ramp map -> out_valid=0 during reset, full correct 144-output map, single pool_done.
